x_encoder_pos_trigger: RTL

- Position-compare trigger generator directly downstream of the X quadrature encoder counter.
- Consumes the counter's signed 32-bit position stream (strobe, position, zero flag).
- Emits a fixed-width trigger pulse each time the axis crosses an equally spaced position point inside a programmed [start, end] window, then reports completion.
- Used to fire acquisition/laser timing on position rather than time.

---
 rtl/x_encoder_pos_trigger.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/x_encoder_pos_trigger.sv
// ---------------------------------------------------------------------------
// x_encoder_pos_trigger
//
// Position-compare trigger generator fed by the X quadrature encoder counter.
// After an arm request it watches the signed position stream and fires a
// PULSE_W-cycle trigger each time the axis reaches the next equally spaced
// point in the programmed [start, end] window. When the window is used up it
// pulses done_o.
//
// Ports
//   clk, rst_n    : system clock, asynchronous active-low reset
//   arm_i         : one-cycle request to latch start/end/step and open a window
//   abort_i       : abandon the current window (ignored in IDLE)
//   start_pos_i   : first trigger position (signed)
//   end_pos_i     : last allowed trigger position (signed)
//   step_i        : unsigned trigger spacing, 0 rejected with err_o
//   zero_flag_i   : encoder re-zero strobe, aborts an armed window with err_o
//   pos_en_i      : position-valid strobe
//   pos_i         : current position (signed)
//   trig_o        : trigger pulse, PULSE_W cycles, extended by back-to-back hits
//   trig_cnt_o    : triggers fired in the current/last window (saturating)
//   busy_o        : high whenever a window is open or completing
//   done_o        : one-cycle pulse on normal completion
//   err_o         : one-cycle pulse on rejected arm or zero-abort
// ---------------------------------------------------------------------------
module x_encoder_pos_trigger #(
    parameter int POS_W   = 32,
    parameter int STEP_W  = 16,
    parameter int CNT_W   = 16,
    parameter int PULSE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic [POS_W-1:0]  start_pos_i,
    input  logic [POS_W-1:0]  end_pos_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic              zero_flag_i,
    input  logic              pos_en_i,
    input  logic [POS_W-1:0]  pos_i,
    output logic              trig_o,
    output logic [CNT_W-1:0]  trig_cnt_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int PC_W = $clog2(PULSE_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic signed [POS_W-1:0] next_pos;
    logic signed [POS_W-1:0] end_pos;
    logic [STEP_W-1:0]       step;
    logic                    fwd;
    logic [CNT_W-1:0]        trig_cnt;
    logic [PC_W-1:0]         pulse_cnt;
    logic                    err_q;

    logic active, arm_ok, arm_bad, abort_any, zero_abort, hit, past_end;
    logic signed [POS_W:0] step_ext, next_ext, end_ext, nxt_ext;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign active     = (state == ARMED) || (state == RUN);
    assign arm_ok     = (state == IDLE) && arm_i && (step_i != '0);
    assign arm_bad    = (state == IDLE) && arm_i && (step_i == '0);
    assign abort_any  = (state != IDLE) && abort_i;
    // abort outranks the zero strobe, which in turn outranks any hit
    assign zero_abort = active && !abort_i && zero_flag_i;

    // One extra bit so that stepping past the end of the position range is
    // detected as "past end" rather than wrapping back into the window.
    assign step_ext = $signed({{(POS_W + 1 - STEP_W){1'b0}}, step});
    assign next_ext = {next_pos[POS_W-1], next_pos};
    assign end_ext  = {end_pos[POS_W-1], end_pos};
    assign nxt_ext  = fwd ? (next_ext + step_ext) : (next_ext - step_ext);

    // Only the single pending point is compared, so one strobe fires at most
    // one trigger and jitter back across an already-fired point is harmless.
    assign hit = active && !abort_i && !zero_flag_i && pos_en_i &&
                 (fwd ? ($signed(pos_i) >= next_pos) : ($signed(pos_i) <= next_pos));
    assign past_end = fwd ? (nxt_ext > end_ext) : (nxt_ext < end_ext);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (arm_ok) state_nxt = ARMED;
            end
            ARMED, RUN: begin
                if (abort_i || zero_flag_i) state_nxt = IDLE;
                else if (hit)               state_nxt = past_end ? DONE : RUN;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy_o     = (state != IDLE);
        done_o     = (state == DONE);
        trig_o     = (pulse_cnt != '0);
        err_o      = err_q;
        trig_cnt_o = trig_cnt;
    end

    // Window configuration, trigger count and pulse stretcher
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_pos  <= '0;
            end_pos   <= '0;
            step      <= '0;
            fwd       <= 1'b0;
            trig_cnt  <= '0;
            pulse_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= arm_bad || zero_abort;

            if (arm_ok) begin
                next_pos <= $signed(start_pos_i);
                end_pos  <= $signed(end_pos_i);
                step     <= step_i;
                fwd      <= ($signed(end_pos_i) >= $signed(start_pos_i));
                trig_cnt <= '0;
            end else if (hit) begin
                trig_cnt <= sat_inc(trig_cnt);
                if (!past_end) next_pos <= nxt_ext[POS_W-1:0];
            end

            // A hit during a running pulse reloads it, so the pulse stretches
            // without a low gap.
            if (abort_any || zero_abort) begin
                pulse_cnt <= '0;
            end else if (hit) begin
                pulse_cnt <= PC_W'(PULSE_W);
            end else if (pulse_cnt != '0) begin
                pulse_cnt <= pulse_cnt - PC_W'(1);
            end
        end
    end

endmodule
